// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction RAM bus, instruction handshake and redirect bundle for instr_fetch
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output mem_addr, mem_rd, instr, instr_pc, instr_valid,
    input  mem_rdata, instr_ready, redirect, redirect_pc
  );

  // RAM / controller side
  modport slave (
    input  mem_addr, mem_rd, instr, instr_pc, instr_valid,
    output mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and instruction fetch front end; INSTR_FETCH_PREFETCH_EN adds in-flight read plus 1-entry buffer
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pc,
  instr_fetch_if.master     bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              ivalid_q, ivalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] bpc_q, bpc_d;
  logic              bvalid_q, bvalid_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              accept;
  logic [1:0]        occ;
  logic [1:0]        occ_after;

  // Register file: IR, prefetch buffer and in-flight read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= start_pc;
      instr_q  <= '0;
      ipc_q    <= '0;
      ivalid_q <= 1'b0;
      addr_q   <= '0;
      buf_q    <= '0;
      bpc_q    <= '0;
      bvalid_q <= 1'b0;
      infl_q   <= 1'b0;
      fpc_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ivalid_q <= ivalid_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      bpc_q    <= bpc_d;
      bvalid_q <= bvalid_d;
      infl_q   <= infl_d;
      fpc_q    <= fpc_d;
    end
  end

  // Issue a read whenever IR + buffer would still have a free slot for its data
  always_comb begin
    accept    = ivalid_q & bus.instr_ready;
    occ       = {1'b0, ivalid_q} + {1'b0, bvalid_q} + {1'b0, infl_q};
    occ_after = occ - {1'b0, accept};
    rd        = !bus.redirect && (occ_after < 2'd2);

    pc_d     = pc_q + {{(ADDR_W-1){1'b0}}, rd};
    addr_d   = rd ? pc_q : addr_q;
    infl_d   = rd;
    fpc_d    = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    ivalid_d = ivalid_q;
    buf_d    = buf_q;
    bpc_d    = bpc_q;
    bvalid_d = bvalid_q;

    if (!ivalid_q || accept) begin
      // IR is free this edge: oldest word (buffer first, then arriving data) moves in
      if (bvalid_q) begin
        instr_d  = buf_q;
        ipc_d    = bpc_q;
        ivalid_d = 1'b1;
        bvalid_d = infl_q;
        if (infl_q) begin
          buf_d = bus.mem_rdata;
          bpc_d = fpc_q;
        end
      end else if (infl_q) begin
        instr_d  = bus.mem_rdata;
        ipc_d    = fpc_q;
        ivalid_d = 1'b1;
      end else begin
        ivalid_d = 1'b0;
      end
    end else if (infl_q) begin
      buf_d    = bus.mem_rdata;
      bpc_d    = fpc_q;
      bvalid_d = 1'b1;
    end

    // Redirect discards IR validity, buffer and the in-flight read
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      ivalid_d = 1'b0;
      bvalid_d = 1'b0;
      infl_d   = 1'b0;
    end
  end
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state_q, state_d;

  // State register, PC and IR
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= start_pc;
      instr_q  <= '0;
      ipc_q    <= '0;
      ivalid_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ivalid_q <= ivalid_d;
      addr_q   <= addr_d;
    end
  end

  // Request / wait for RAM / hold until accepted; redirect restarts at the new PC
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    ivalid_d = ivalid_q;
    addr_d   = addr_q;
    rd       = 1'b0;
    case (state_q)
      S_REQ: begin
        rd      = 1'b1;
        addr_d  = pc_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        instr_d  = bus.mem_rdata;
        ipc_d    = pc_q;
        pc_d     = pc_q + PC_ONE;
        ivalid_d = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          ivalid_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      ivalid_d = 1'b0;
      state_d  = S_REQ;
    end
  end
`endif

  // The RAM sees no strobe and a zero address while reset is held
  assign bus.mem_rd      = rd & ~rst;
  assign bus.mem_addr    = rst ? '0 : (rd ? pc_q : addr_q);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = ivalid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

`ifdef INSTR_FETCH_PREFETCH_EN
  localparam int GAP = 0;
  localparam int PER = 1;
  localparam logic [7:0] WRAP_LAST_ADDR = 8'h00;
`else
  localparam int GAP = 2;
  localparam int PER = 3;
  localparam logic [7:0] WRAP_LAST_ADDR = 8'hFF;
`endif

  localparam logic [15:0] SEQ [3] = '{16'hA001, 16'hB002, 16'hC003};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] start_pc;
  logic [15:0] ram [256];
  int checks = 0;
  int failures = 0;

  instr_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_fetch #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_pc (start_pc),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.instr_valid && n < max) begin
      tick();
      n++;
    end
    if (!bus.instr_valid) n = -1;
  endtask

  task automatic do_reset(input logic [7:0] pc, input int cycles);
    rst = 1'b1;
    start_pc = pc;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1; start_pc = 8'h00;
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
    repeat (3) tick();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.instr !== 16'h0000) begin failures++; $display("FAIL rst_instr got=%h exp=0000", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL rst_instr_pc got=%h exp=00", bus.instr_pc); end
    checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL rst_mem_rd got=%b exp=0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== 8'h00) begin failures++; $display("FAIL rst_mem_addr got=%h exp=00", bus.mem_addr); end
    rst = 1'b0;
    tick();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", bus.instr_valid); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== 16'hA001) begin failures++; $display("FAIL first_instr got=%h exp=A001", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL first_pc got=%h exp=00", bus.instr_pc); end
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA001 || bus.instr_pc !== 8'h00) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL hold_stable got=%b exp=0 last_instr=%h", bad, bus.instr); end
    checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL hold_mem_rd got=%b exp=0", bus.mem_rd); end
  endtask

  task automatic test_sequence();
    int n;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.instr !== SEQ[i]) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.instr, SEQ[i]); end
      checks++; if (bus.instr_pc !== 8'(i)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.instr_pc, 8'(i)); end
      if (i < 2) begin
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        wait_valid(10, n);
        checks++; if (n !== GAP) begin failures++; $display("FAIL seq_gap[%0d] got=%0d exp=%0d", i, n, GAP); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [3];
    int gt [3];
    int cnt;
    cnt = 0;
    do_reset(8'h00, 2);
    bus.instr_ready = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.instr_valid && cnt < 3) begin
        got[cnt] = bus.instr;
        gt[cnt] = t;
        cnt++;
      end
    end
    bus.instr_ready = 1'b0;
    checks++; if (cnt !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", cnt); end
    for (int i = 0; i < 3; i++) begin
      if (i < cnt) begin
        checks++; if (got[i] !== SEQ[i]) begin failures++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, got[i], SEQ[i]); end
        checks++; if (gt[i] !== 2 + i * PER) begin failures++; $display("FAIL b2b_time[%0d] got=%0d exp=%0d", i, gt[i], 2 + i * PER); end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    ram[8'hFF] = 16'h1234;
    ram[8'h00] = 16'h5678;
    do_reset(8'hFF, 2);
    tick(); tick();
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== 16'h1234) begin failures++; $display("FAIL wrap_instr0 got=%h exp=1234", bus.instr); end
    checks++; if (bus.instr_pc !== 8'hFF) begin failures++; $display("FAIL wrap_pc0 got=%h exp=FF", bus.instr_pc); end
    checks++; if (bus.mem_addr !== WRAP_LAST_ADDR) begin failures++; $display("FAIL wrap_addr_hold got=%h exp=%h", bus.mem_addr, WRAP_LAST_ADDR); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    wait_valid(10, n);
    checks++; if (bus.instr !== 16'h5678) begin failures++; $display("FAIL wrap_instr1 got=%h exp=5678", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL wrap_pc1 got=%h exp=00", bus.instr_pc); end
    ram[8'h00] = 16'hA001;
  endtask

  task automatic test_redirect();
    int n;
    ram[8'h10] = 16'hDEAD;
    ram[8'h11] = 16'hBEEF;
    ram[8'h12] = 16'h7777;
    do_reset(8'h00, 3);
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 8'h10;
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", bus.instr_valid); end
    wait_valid(10, n);
    checks++; if (n < 0) begin failures++; $display("FAIL redir_timeout got=%0d exp=>=0", n); end
    checks++; if (bus.instr !== 16'hDEAD) begin failures++; $display("FAIL redir_instr got=%h exp=DEAD", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h10) begin failures++; $display("FAIL redir_pc got=%h exp=10", bus.instr_pc); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    wait_valid(10, n);
    checks++; if (bus.instr !== 16'hBEEF) begin failures++; $display("FAIL redir_next got=%h exp=BEEF", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h11) begin failures++; $display("FAIL redir_next_pc got=%h exp=11", bus.instr_pc); end
    bus.redirect = 1'b1; bus.redirect_pc = 8'h10; bus.instr_ready = 1'b1;
    tick();
    bus.redirect = 1'b0; bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_ready_flush got=%b exp=0", bus.instr_valid); end
    wait_valid(10, n);
    checks++; if (bus.instr !== 16'hDEAD) begin failures++; $display("FAIL redir_ready_instr got=%h exp=DEAD", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h10) begin failures++; $display("FAIL redir_ready_pc got=%h exp=10", bus.instr_pc); end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1; start_pc = 8'h01;
    tick();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.instr !== 16'h0000) begin failures++; $display("FAIL midrst_instr got=%h exp=0000", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL midrst_pc got=%h exp=00", bus.instr_pc); end
    rst = 1'b0;
    wait_valid(10, n);
    checks++; if (n !== 2) begin failures++; $display("FAIL midrst_latency got=%0d exp=2", n); end
    checks++; if (bus.instr !== 16'hB002) begin failures++; $display("FAIL midrst_refetch got=%h exp=B002", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h01) begin failures++; $display("FAIL midrst_refetch_pc got=%h exp=01", bus.instr_pc); end
  endtask

  task automatic test_ready_idle();
    rst = 1'b1; start_pc = 8'h02; bus.instr_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", bus.instr_valid); end
    tick();
    bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL idle_first_valid got=%b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== 16'hC003) begin failures++; $display("FAIL idle_first_instr got=%h exp=C003", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h02) begin failures++; $display("FAIL idle_first_pc got=%h exp=02", bus.instr_pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h9000 | 16'(i);
    ram[0] = 16'hA001; ram[1] = 16'hB002; ram[2] = 16'hC003;
    test_reset();
    test_sequence();
    test_back_to_back();
    test_wrap();
    test_redirect();
    test_reset_mid();
    test_ready_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
